// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the 1RW+1R SRAM port controller.
package sram_ctrl_pkg;

    localparam int SRAM_DATA_WIDTH = 128;
    localparam int SRAM_ADDR_WIDTH = 8;
    localparam int SRAM_NUM_WMASKS = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_pipe_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves to the loser after every grant.
module sram_rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1
);

    req_id_t prio_r;
    req_id_t prio_next_s;
    logic    gnt0_s;
    logic    gnt1_s;

    // Grant selection; no grant is issued while reset is held.
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        prio_next_s = prio_r;
        if (rst) begin
            prio_next_s = REQ0;
        end else if (valid0 && (!valid1 || (prio_r == REQ0))) begin
            gnt0_s      = 1'b1;
            prio_next_s = REQ1;
        end else if (valid1) begin
            gnt1_s      = 1'b1;
            prio_next_s = REQ0;
        end else begin
            prio_next_s = prio_r;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= REQ0;
        end else begin
            prio_r <= prio_next_s;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

endmodule

// File: rtl/sram_1rw1r_port_arbiter.sv
// Shares a 1RW+1R SRAM macro: two arbitrated requesters on port 0, a dedicated reader on port 1.
module sram_1rw1r_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = sram_ctrl_pkg::SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_ctrl_pkg::SRAM_ADDR_WIDTH,
    parameter int NUM_WMASKS = sram_ctrl_pkg::SRAM_NUM_WMASKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic                  gnt0_s, gnt1_s, gnt_any_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [NUM_WMASKS-1:0] sel_wmask_s;
    logic                  collision_s, rd_accept_s;
    rd_pipe_t              pipe_next_s, pipe_r;

    logic                  web0_r;
    logic [ADDR_WIDTH-1:0] addr0_r;
    logic [DATA_WIDTH-1:0] din0_r;
    logic [NUM_WMASKS-1:0] wmask0_r;

    logic                  rsp0_valid_r, rsp1_valid_r, rd_p0_r, rd_rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp0_rdata_r, rsp1_rdata_r, rd_rsp_rdata_r;

    sram_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .gnt0   (gnt0_s),
        .gnt1   (gnt1_s)
    );

    assign gnt_any_s  = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Issue mux and collision check for the granted port-0 request.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_wmask_s = '0;
        if (gnt1_s) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
            sel_wmask_s = req1_wmask;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
            sel_wmask_s = req0_wmask;
        end
        collision_s       = gnt_any_s && sel_we_s && (|sel_wmask_s) && (sel_addr_s == rd_addr);
        pipe_next_s.valid = gnt_any_s && !sel_we_s;
        pipe_next_s.id    = gnt1_s ? REQ1 : REQ0;
    end

    // Last issued port-0 pin values, replayed while idle so the macro pins stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            web0_r   <= 1'b1;
            addr0_r  <= '0;
            din0_r   <= '0;
            wmask0_r <= '0;
        end else if (gnt_any_s) begin
            web0_r   <= ~sel_we_s;
            addr0_r  <= sel_addr_s;
            din0_r   <= sel_wdata_s;
            wmask0_r <= sel_wmask_s;
        end
    end

    assign sram_csb0   = ~gnt_any_s;
    assign sram_web0   = gnt_any_s ? ~sel_we_s   : web0_r;
    assign sram_addr0  = gnt_any_s ? sel_addr_s  : addr0_r;
    assign sram_din0   = gnt_any_s ? sel_wdata_s : din0_r;
    assign sram_wmask0 = gnt_any_s ? sel_wmask_s : wmask0_r;

    // The reader stalls one cycle behind a same-address write so it sees the new data.
    assign rd_ready    = ~rst & ~collision_s;
    assign rd_accept_s = rd_valid & rd_ready;
    assign sram_csb1   = ~rd_accept_s;
    assign sram_addr1  = rd_addr;

    // Read pipelines and response registers; macro data is captured one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_r         <= '0;
            rsp0_valid_r   <= 1'b0;
            rsp1_valid_r   <= 1'b0;
            rsp0_rdata_r   <= '0;
            rsp1_rdata_r   <= '0;
            rd_p0_r        <= 1'b0;
            rd_rsp_valid_r <= 1'b0;
            rd_rsp_rdata_r <= '0;
        end else begin
            pipe_r         <= pipe_next_s;
            rsp0_valid_r   <= pipe_r.valid && (pipe_r.id == REQ0);
            rsp1_valid_r   <= pipe_r.valid && (pipe_r.id == REQ1);
            if (pipe_r.valid && (pipe_r.id == REQ0)) rsp0_rdata_r <= sram_dout0;
            if (pipe_r.valid && (pipe_r.id == REQ1)) rsp1_rdata_r <= sram_dout0;
            rd_p0_r        <= rd_accept_s;
            rd_rsp_valid_r <= rd_p0_r;
            if (rd_p0_r) rd_rsp_rdata_r <= sram_dout1;
        end
    end

    assign rsp0_valid   = rsp0_valid_r;
    assign rsp1_valid   = rsp1_valid_r;
    assign rsp0_rdata   = rsp0_rdata_r;
    assign rsp1_rdata   = rsp1_rdata_r;
    assign rd_rsp_valid = rd_rsp_valid_r;
    assign rd_rsp_rdata = rd_rsp_rdata_r;

endmodule
